// File: rtl/gshare_predictor_pkg.sv
// rtl/gshare_predictor_pkg.sv - shared branch predictor parameters and types
package gshare_predictor_pkg;

    // Machine word width and predictor defaults used across the core
    localparam int XLEN        = 32;
    localparam int BP_IDX_W    = 8;
    localparam int BP_CNT_W    = 2;
    localparam int BP_HIST_LEN = 8;
    localparam int BP_MODE     = 1;

    // Table indexing scheme
    typedef enum logic {
        IDX_BIMODAL = 1'b0,
        IDX_GSHARE  = 1'b1
    } idx_mode_e;

endpackage

// File: rtl/bp_history_reg.sv
// rtl/bp_history_reg.sv - speculative and committed global history pair
module bp_history_reg #(
    parameter int HIST_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                spec_shift_i,
    input  logic                spec_bit_i,
    input  logic                commit_shift_i,
    input  logic                commit_bit_i,
    output logic [HIST_LEN-1:0] ghr_spec_o
);

    logic [HIST_LEN-1:0] spec_q, spec_d;
    logic [HIST_LEN-1:0] commit_q, commit_d;

    // Next history: commit always shifts on an update; a flush restores the
    // speculative copy from the post-update committed value and drops fetch shifts
    always_comb begin
        commit_d = commit_q;
        if (commit_shift_i) begin
            commit_d = HIST_LEN'({commit_q, commit_bit_i});
        end
        spec_d = spec_q;
        if (flush) begin
            spec_d = commit_d;
        end else if (spec_shift_i) begin
            spec_d = HIST_LEN'({spec_q, spec_bit_i});
        end
    end

    // History registers; frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_q   <= '0;
            commit_q <= '0;
        end else if (rdy) begin
            spec_q   <= spec_d;
            commit_q <= commit_d;
        end
    end

    assign ghr_spec_o = spec_q;

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare/bimodal conditional branch predictor
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int IDX_W    = BP_IDX_W,
    parameter int CNT_W    = BP_CNT_W,
    parameter int HIST_LEN = BP_HIST_LEN,
    parameter int MODE     = BP_MODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             fet_valid,
    input  logic             fet_is_br,
    input  logic [XLEN-1:0]  fet_pc,
    output logic             bp_pred,
    output logic [IDX_W-1:0] bp_idx,
    input  logic             rob_bp_enable,
    input  logic [IDX_W-1:0] rob_bp_idx,
    input  logic             rob_bp_jump,
    input  logic             rob_bp_correct,
    output logic [XLEN-1:0]  bp_correct_cnt,
    output logic [XLEN-1:0]  bp_total_cnt
);

    localparam int               ENTRIES  = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0]    cnt_q [ENTRIES];
    logic [CNT_W-1:0]    cnt_cur, cnt_upd_d;
    logic [XLEN-1:0]     correct_q, correct_d;
    logic [XLEN-1:0]     total_q, total_d;
    logic [HIST_LEN-1:0] ghr_spec;
    logic [IDX_W-1:0]    hist_ext;
    logic [IDX_W-1:0]    pc_idx;
    logic                update_en;
    logic                unused_pc_bits;

    // PC bit 0 and everything above the index field never affect the table
    assign unused_pc_bits = ^{fet_pc[XLEN-1:IDX_W+1], fet_pc[0]};

    assign update_en = rdy && rob_bp_enable;
    assign pc_idx    = fet_pc[IDX_W:1];

    // Zero-extend the speculative history up to the index width
    always_comb begin
        hist_ext                = '0;
        hist_ext[HIST_LEN-1:0]  = ghr_spec;
    end

    assign bp_idx  = (MODE == int'(IDX_GSHARE)) ? (pc_idx ^ hist_ext) : pc_idx;
    assign bp_pred = cnt_q[bp_idx][CNT_W-1];

    // Saturating step of the counter addressed by the committing branch
    always_comb begin
        cnt_cur   = cnt_q[rob_bp_idx];
        cnt_upd_d = cnt_cur;
        if (rob_bp_jump && (cnt_cur != CNT_MAX)) begin
            cnt_upd_d = cnt_cur + 1'b1;
        end else if (!rob_bp_jump && (cnt_cur != '0)) begin
            cnt_upd_d = cnt_cur - 1'b1;
        end
    end

    // Counter table: reset to weakly not-taken, one entry written per update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (update_en) begin
            cnt_q[rob_bp_idx] <= cnt_upd_d;
        end
    end

    // Next value of the committed-branch statistics
    always_comb begin
        correct_d = correct_q;
        total_d   = total_q;
        if (update_en) begin
            total_d = total_q + 1'b1;
            if (rob_bp_correct) begin
                correct_d = correct_q + 1'b1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            correct_q <= '0;
            total_q   <= '0;
        end else begin
            correct_q <= correct_d;
            total_q   <= total_d;
        end
    end

    assign bp_correct_cnt = correct_q;
    assign bp_total_cnt   = total_q;

    bp_history_reg #(
        .HIST_LEN (HIST_LEN)
    ) u_history (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .spec_shift_i   (fet_valid && fet_is_br),
        .spec_bit_i     (bp_pred),
        .commit_shift_i (rob_bp_enable),
        .commit_bit_i   (rob_bp_jump),
        .ghr_spec_o     (ghr_spec)
    );

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - randomized self-checking bench for gshare_predictor
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

    localparam int IDX_W    = 8;
    localparam int CNT_W    = 2;
    localparam int HIST_LEN = 8;
    localparam int MODE     = 1;
    localparam int IDX_MASK = (1 << IDX_W) - 1;
    localparam int H_MASK   = (1 << HIST_LEN) - 1;
    localparam int C_MAX    = (1 << CNT_W) - 1;
    localparam int C_INIT   = (1 << (CNT_W - 1)) - 1;
    localparam int C_TAKEN  = 1 << (CNT_W - 1);

    logic             clk = 1'b0;
    logic             rst, rdy, flush, fet_valid, fet_is_br;
    logic [XLEN-1:0]  fet_pc;
    logic             bp_pred;
    logic [IDX_W-1:0] bp_idx;
    logic             rob_bp_enable, rob_bp_jump, rob_bp_correct;
    logic [IDX_W-1:0] rob_bp_idx;
    logic [XLEN-1:0]  bp_correct_cnt, bp_total_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    int              m_cnt [1 << IDX_W];
    int              m_spec, m_commit;
    logic [XLEN-1:0] m_total, m_correct;

    gshare_predictor #(
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W),
        .HIST_LEN (HIST_LEN),
        .MODE     (MODE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .fet_valid      (fet_valid),
        .fet_is_br      (fet_is_br),
        .fet_pc         (fet_pc),
        .bp_pred        (bp_pred),
        .bp_idx         (bp_idx),
        .rob_bp_enable  (rob_bp_enable),
        .rob_bp_idx     (rob_bp_idx),
        .rob_bp_jump    (rob_bp_jump),
        .rob_bp_correct (rob_bp_correct),
        .bp_correct_cnt (bp_correct_cnt),
        .bp_total_cnt   (bp_total_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_idx();
        int pcf;
        pcf = int'((fet_pc >> 1) & XLEN'(IDX_MASK));
        return (MODE != 0) ? (pcf ^ (m_spec & IDX_MASK)) : pcf;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << IDX_W); i++) m_cnt[i] = C_INIT;
        m_spec    = 0;
        m_commit  = 0;
        m_total   = '0;
        m_correct = '0;
    endtask

    // Inputs are already driven; compare outputs mid-cycle, then advance model at the edge
    task automatic step(input bit chk = 1'b1);
        int p_idx, p_pred, j;
        #2;
        p_idx  = model_idx();
        p_pred = (m_cnt[p_idx] >= C_TAKEN) ? 1 : 0;
        if (chk) begin
            check_eq("bp_idx", 64'(bp_idx), 64'(p_idx));
            check_eq("bp_pred", 64'(bp_pred), 64'(p_pred));
            check_eq("bp_total_cnt", 64'(bp_total_cnt), 64'(m_total));
            check_eq("bp_correct_cnt", 64'(bp_correct_cnt), 64'(m_correct));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            if (rob_bp_enable) begin
                j = int'(rob_bp_idx);
                m_cnt[j] = rob_bp_jump ? ((m_cnt[j] < C_MAX) ? m_cnt[j] + 1 : C_MAX)
                                       : ((m_cnt[j] > 0) ? m_cnt[j] - 1 : 0);
                m_total = m_total + 1;
                if (rob_bp_correct) m_correct = m_correct + 1;
                m_commit = ((m_commit << 1) | int'(rob_bp_jump)) & H_MASK;
            end
            if (flush) m_spec = m_commit;
            else if (fet_valid && fet_is_br) m_spec = ((m_spec << 1) | p_pred) & H_MASK;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; fet_valid = 0; fet_is_br = 0; fet_pc = '0;
        rob_bp_enable = 0; rob_bp_idx = '0; rob_bp_jump = 0; rob_bp_correct = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step(1'b0);
        rst = 0;
    endtask

    initial begin
        idle();
        model_reset();
        do_reset();

        // Reset state seen at fetch PC 0x100
        fet_valid = 1; fet_pc = 32'h100;
        #2;
        check_eq("rst_idx", 64'(bp_idx), 64'h80);
        check_eq("rst_pred", 64'(bp_pred), 64'h0);
        check_eq("rst_total", 64'(bp_total_cnt), 64'h0);
        check_eq("rst_correct", 64'(bp_correct_cnt), 64'h0);
        step();

        // Three taken updates saturate entry 0x80
        fet_valid = 0;
        rob_bp_enable = 1; rob_bp_idx = 8'h80; rob_bp_jump = 1; rob_bp_correct = 1;
        repeat (3) step();
        rob_bp_enable = 0;
        fet_valid = 1; fet_pc = 32'h100;
        #2;
        check_eq("sat_pred", 64'(bp_pred), 64'h1);
        check_eq("sat_total", 64'(bp_total_cnt), 64'h3);
        step();

        // Speculative history 0b10 steers the next index
        fet_is_br = 1; fet_pc = 32'h100;
        step();
        fet_pc = 32'h200;
        #2;
        check_eq("hist_pred0", 64'(bp_pred), 64'h0);
        step();
        fet_is_br = 0; fet_pc = 32'h100;
        #2;
        check_eq("hist_idx", 64'(bp_idx), 64'h82);
        step();

        // Flush restores from the commit history including the same-cycle commit
        do_reset();
        rob_bp_enable = 1; rob_bp_idx = 8'h10; rob_bp_jump = 1;
        step();
        flush = 1; fet_valid = 1; fet_is_br = 1; fet_pc = 32'h100;
        step();
        flush = 0; rob_bp_enable = 0; fet_is_br = 0;
        #2;
        check_eq("flush_idx", 64'(bp_idx), 64'h83);
        step();
        flush = 1;
        step();
        flush = 0;
        #2;
        check_eq("flush_commit", 64'(bp_idx), 64'h83);
        step();

        // rdy low freezes everything
        rdy = 0; rob_bp_enable = 1; rob_bp_idx = 8'h80; rob_bp_jump = 1;
        fet_is_br = 1; fet_pc = 32'h106;
        repeat (5) step();
        rdy = 1; rob_bp_enable = 0; fet_is_br = 0;
        #2;
        check_eq("frz_total", 64'(bp_total_cnt), 64'h2);
        check_eq("frz_idx", 64'(bp_idx), 64'h80);
        check_eq("frz_pred", 64'(bp_pred), 64'h0);
        step();

        // Same-cycle update of the predicted entry is not forwarded
        do_reset();
        fet_valid = 1; fet_pc = 32'h100;
        rob_bp_enable = 1; rob_bp_idx = 8'h80; rob_bp_jump = 1;
        #2;
        check_eq("fwd_same", 64'(bp_pred), 64'h0);
        step();
        rob_bp_enable = 0;
        #2;
        check_eq("fwd_next", 64'(bp_pred), 64'h1);
        step();

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 299) == 0);
            rdy            = ($urandom_range(0, 7) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            fet_valid      = ($urandom_range(0, 3) != 0);
            fet_is_br      = $urandom_range(0, 1);
            fet_pc         = $urandom;
            rob_bp_enable  = $urandom_range(0, 1);
            rob_bp_idx     = IDX_W'($urandom_range(0, 7) * 32 + $urandom_range(0, 1));
            rob_bp_jump    = ($urandom_range(0, 2) != 0);
            rob_bp_correct = $urandom_range(0, 1);
            step();
        end

        // Reset in the middle of active traffic
        rdy = 1; flush = 1; fet_valid = 1; fet_is_br = 1; rob_bp_enable = 1; rst = 1;
        step();
        idle();
        for (int k = 0; k < 8; k++) begin
            fet_pc = $urandom;
            #2;
            check_eq("post_rst_pred", 64'(bp_pred), 64'h0);
            check_eq("post_rst_idx", 64'(bp_idx), 64'(fet_pc[IDX_W:1]));
            step();
        end
        check_eq("post_rst_total", 64'(bp_total_cnt), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
